// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 4-entry byte FIFO feeding an 8N1 UART transmitter
// Line is driven from a flop; frames chain back-to-back while bytes are queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        uart_tx_q, uart_tx_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];

  logic push;
  logic pop;
  logic baud_done;

  assign tx_ready  = (count_q < 3'd4);
  assign push      = tx_valid && tx_ready;
  assign baud_done = (baud_cnt_q == BAUD_LAST);
  assign tx_busy   = (state_q != IDLE) || (count_q != 3'd0);
  assign uart_tx   = uart_tx_q;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  // The pop edge also loads the shifter and drops the line for the start bit.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    uart_tx_d  = uart_tx_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        uart_tx_d  = 1'b1;
        baud_cnt_d = 16'd0;
        if (count_q != 3'd0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          state_d   = START;
          uart_tx_d = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          uart_tx_d  = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            uart_tx_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            uart_tx_d = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_d = 16'd0;
          if (count_q != 3'd0) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            state_d   = START;
            uart_tx_d = 1'b0;
          end else begin
            state_d   = IDLE;
            uart_tx_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        uart_tx_d = 1'b1;
      end
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      uart_tx_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
// Queue-and-timeline model checked every cycle, plus literal expectations per scenario.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  logic [7:0] mq[$];
  logic [7:0] sent[$];
  bit         in_frame = 1'b0;
  int         t = 0;
  logic [7:0] cur = 8'h00;

  uart_tx_fifo #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame timeline: t counts clocks since the start-bit edge; bit slot = t / DIV.
  function automatic int exp_line();
    int slot;
    if (!in_frame) return 1;
    slot = t / DIV;
    if (slot == 0) return 0;
    if (slot == 9) return 1;
    return int'(cur[slot-1]);
  endfunction

  task automatic model_step();
    bit accept;
    accept = tx_valid && (mq.size() < 4);
    if (!in_frame) begin
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        sent.push_back(cur);
        in_frame = 1'b1;
        t = 0;
      end
    end else if (t == FRAME - 1) begin
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        sent.push_back(cur);
        t = 0;
      end else begin
        in_frame = 1'b0;
      end
    end else begin
      t++;
    end
    if (accept) mq.push_back(tx_data);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      in_frame = 1'b0;
      t = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    check("uart_tx", int'(uart_tx), exp_line());
    check("tx_ready", int'(tx_ready), int'(mq.size() < 4));
    check("tx_busy", int'(tx_busy), int'(in_frame || (mq.size() != 0)));
    if (tx_busy) busy_cycles++;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int waited);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%0h waited=%0d required<2000", b, n);
    end
    @(negedge clk);
    waited = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0d required=0", tx_busy);
    end
  endtask

  task automatic check_sent(input string name, input int base, input logic [7:0] exp[$]);
    check({name, "_count"}, sent.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < sent.size()) check(name, int'(sent[base+i]), int'(exp[i]));
    end
  endtask

  initial begin
    int w;
    int base;
    int bits55[10];
    logic [7:0] exp_b[$];

    bits55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    repeat (3) @(negedge clk);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_line", int'(uart_tx), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte 0x55
    base = sent.size();
    send(8'h55, w);
    tx_valid = 1'b0;
    check("s55_pre_fall", int'(uart_tx), 1);
    @(negedge clk);
    check("s55_fall", int'(uart_tx), 0);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 5 : 10) @(negedge clk);
      check("s55_bit", int'(uart_tx), bits55[k]);
    end
    repeat (4) @(negedge clk);
    check("s55_busy_last", int'(tx_busy), 1);
    @(negedge clk);
    check("s55_busy_end", int'(tx_busy), 0);
    exp_b = '{8'h55};
    check_sent("s55_order", base, exp_b);

    // back-to-back
    @(negedge clk);
    base = sent.size();
    busy_cycles = 0;
    send(8'h01, w);
    send(8'h02, w);
    send(8'h03, w);
    tx_valid = 1'b0;
    wait_idle();
    check("b2b_busy_cycles", busy_cycles, 1 + 3 * FRAME);
    exp_b = '{8'h01, 8'h02, 8'h03};
    check_sent("b2b_order", base, exp_b);

    // full FIFO
    @(negedge clk);
    base = sent.size();
    busy_cycles = 0;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), w);
    check("full_ready", int'(tx_ready), 0);
    send(8'hA5, w);
    tx_valid = 1'b0;
    check("full_wait", w, 97);
    wait_idle();
    check("full_busy_cycles", busy_cycles, 1 + 6 * FRAME);
    exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    check_sent("full_order", base, exp_b);

    // push on the STOP->START pop edge with two queued
    @(negedge clk);
    base = sent.size();
    send(8'hB0, w);
    send(8'hB1, w);
    send(8'hB2, w);
    tx_valid = 1'b0;
    repeat (98) @(negedge clk);
    send(8'hB3, w);
    send(8'hB4, w);
    send(8'hB5, w);
    tx_valid = 1'b0;
    check("simul_full", int'(tx_ready), 0);
    wait_idle();
    exp_b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    check_sent("simul_order", base, exp_b);

    // reset during bit 3 of 0xFF with two queued
    @(negedge clk);
    base = sent.size();
    send(8'hFF, w);
    send(8'hC1, w);
    send(8'hC2, w);
    tx_valid = 1'b0;
    repeat (44) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_line", int'(uart_tx), 1);
    check("arst_busy", int'(tx_busy), 0);
    check("arst_ready", int'(tx_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_line", int'(uart_tx), 1);
    check("post_rst_busy", int'(tx_busy), 0);
    check("post_rst_ready", int'(tx_ready), 1);
    exp_b = '{8'hFF};
    check_sent("rst_discard", base, exp_b);

    // accept on the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    base = sent.size();
    rst_n = 1'b1;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("first_edge_accept", int'(tx_busy), 1);
    wait_idle();
    exp_b = '{8'h3C};
    check_sent("first_edge_order", base, exp_b);

    // pointer wrap
    @(negedge clk);
    base = sent.size();
    exp_b.delete();
    for (int i = 0; i < 10; i++) begin
      send(8'(i), w);
      exp_b.push_back(8'(i));
    end
    tx_valid = 1'b0;
    wait_idle();
    check_sent("wrap_order", base, exp_b);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL derive localparam BAUD_DIV = CLK_FREQ / BAUD_RATE (integer divide); 2 <= BAUD_DIV <= 65535 is a legal-configuration requirement.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port tx_data  input  8  byte offered by the upstream producer.
REQ-007 SHALL have port tx_valid  input  1  producer asserts while tx_data is valid.
REQ-008 SHALL have port tx_ready  output  1  high when a byte can be accepted this cycle.
REQ-009 SHALL have port tx_busy  output  1  high while any byte is queued or in flight.
REQ-010 SHALL have port uart_tx  output  1  serial line, idle high, 8N1.

Function
REQ-011 SHALL hold bytes in a 4-entry FIFO: 2-bit read/write pointers and a 3-bit count, both pointers wrapping 3->0.
REQ-012 SHALL drive tx_ready = (count < 4), decoded from registered count only, with no combinational path from tx_valid.
REQ-013 SHALL accept a byte on a rising edge with tx_valid && tx_ready; tx_data is written at the write pointer and the write pointer advances.
REQ-014 SHALL ignore tx_valid while full; the byte is not written and count and pointers are unchanged, even if a pop occurs in the same cycle.
REQ-015 SHALL, on a simultaneous push and pop with count in 1..3, perform both and leave count unchanged.
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP, with a 16-bit baud counter and a 3-bit bit index.
REQ-017 SHALL, in IDLE with count != 0, pop the head byte into an 8-bit shift register, enter START, and drive uart_tx low from that same edge.
REQ-018 SHALL make uart_tx fall on the first edge after the edge at which a byte is accepted into an empty FIFO while in IDLE (1-cycle latency).
REQ-019 SHALL hold each of START, DATA-bit and STOP for exactly BAUD_DIV clocks; the baud counter counts 0..BAUD_DIV-1 and then clears.
REQ-020 SHALL, in DATA, send bits LSB first, index 0..7, and enter STOP after bit 7.
REQ-021 SHALL drive uart_tx high during STOP.
REQ-022 SHALL, at the end of STOP with count != 0, pop and enter START on that edge, giving back-to-back frames with zero idle cycles; otherwise it SHALL return to IDLE.
REQ-023 SHALL give a total frame length of exactly 10*BAUD_DIV clocks.
REQ-024 SHALL drive uart_tx = 1 in IDLE.
REQ-025 SHALL drive uart_tx from a flip-flop, glitch-free.
REQ-026 SHALL drive tx_busy = (state != IDLE) || (count != 0).
REQ-027 SHALL not alter the in-flight frame when tx_data or tx_valid change mid-frame.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set uart_tx=1, state=IDLE, count=0, both pointers=0, baud counter=0, bit index=0 and shift register=0.
REQ-029 SHALL, during reset, present tx_ready=1 and tx_busy=0.
REQ-030 SHALL, on reset mid-frame, drive the line high immediately and discard the partial frame and all queued bytes; nothing resumes after release.
REQ-031 SHALL accept a byte on the first rising edge after rst_n deasserts.
REQ-032 SHALL not require FIFO storage contents to be reset.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000, BAUD_DIV=10)
REQ-033 SHALL cover a single byte: push 0x55 while idle -> uart_tx falls 1 cycle later; line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 10 cycles; tx_busy falls after 100 cycles.
REQ-034 SHALL cover back-to-back traffic: push 0x01,0x02,0x03 on consecutive cycles -> three contiguous 100-cycle frames with no idle gap; decoded bytes in order.
REQ-035 SHALL cover the full condition: hold tx_valid with 0xA0..0xA5 during the first frame -> bytes 0xA0..0xA4 accepted (1 in flight plus 4 queued), tx_ready low; 0xA5 is accepted only after the next pop.
REQ-036 SHALL cover simultaneous push and pop: push exactly on the STOP->START pop edge with count=2 -> count stays 2; byte order preserved.
REQ-037 SHALL cover reset mid-frame: assert rst_n low during bit 3 of 0xFF with 2 bytes queued -> uart_tx=1 asynchronously; after release, line idle, tx_busy=0, tx_ready=1.
REQ-038 SHALL cover pointer wrap: stream 10 bytes 0x00..0x09 -> all transmitted in order across pointer wrap 3->0.
